apb_demux_to: RTL

- Parametrised successor to the fixed-map APB peripheral node. Splits one upstream APB (from the host AXI→APB bridge) into NUM_SLV downstream peripheral ports.
- Adds a runtime-programmable address rule table with per-rule enables and a registered one-outstanding transaction FSM.
- Returns a PSLVERR response on a decode miss, and on a peripheral timeout the block aborts the access and returns PSLVERR.
- Sticky error log plus a saturating error counter feed SoC-control status registers.

---
 rtl/apb_demux_to.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/apb_demux_to.sv
// apb_demux_to: APB 1-to-NUM_SLV demux with runtime rule table, timeout abort and sticky error log
module apb_demux_to #(
  parameter int          NUM_SLV     = 11,
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [31:0] ERR_DATA    = 32'hBADC_0FFE,
  parameter int          ERRCNT_W    = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [ADDR_W-1:0]         s_paddr_i,
  input  logic [DATA_W-1:0]         s_pwdata_i,
  input  logic                      s_pwrite_i,
  input  logic                      s_psel_i,
  input  logic                      s_penable_i,
  output logic [DATA_W-1:0]         s_prdata_o,
  output logic                      s_pready_o,
  output logic                      s_pslverr_o,
  input  logic [NUM_SLV*ADDR_W-1:0] start_addr_i,
  input  logic [NUM_SLV*ADDR_W-1:0] end_addr_i,
  input  logic [NUM_SLV-1:0]        rule_en_i,
  output logic [ADDR_W-1:0]         m_paddr_o,
  output logic [DATA_W-1:0]         m_pwdata_o,
  output logic                      m_pwrite_o,
  output logic [NUM_SLV-1:0]        m_psel_o,
  output logic                      m_penable_o,
  input  logic [NUM_SLV*DATA_W-1:0] m_prdata_i,
  input  logic [NUM_SLV-1:0]        m_pready_i,
  input  logic [NUM_SLV-1:0]        m_pslverr_i,
  input  logic                      err_clr_i,
  output logic                      err_valid_o,
  output logic                      err_type_o,
  output logic [ADDR_W-1:0]         err_addr_o,
  output logic [ERRCNT_W-1:0]       err_cnt_o
);
  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [DATA_W-1:0] ERR_D = DATA_W'(ERR_DATA);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_rdata;
  logic                r_write, r_slverr;
  logic [IDX_W-1:0]    r_idx, w_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err_valid, r_err_type;
  logic [ADDR_W-1:0]   r_err_addr;
  logic [ERRCNT_W-1:0] r_err_cnt;
  logic                w_hit, w_accept, w_rdy, w_tout, w_act, w_err;
  logic [ADDR_W-1:0]   w_err_addr;

  assign w_accept   = (r_state == IDLE) && s_psel_i && !s_penable_i;
  assign w_rdy      = m_pready_i[r_idx];
  assign w_tout     = (TIMEOUT_CYC != 0) && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign w_act      = (r_state == SETUP) || (r_state == ACCESS);
  assign w_err      = (w_accept && !w_hit) || ((r_state == ACCESS) && !w_rdy && w_tout);
  assign w_err_addr = (r_state == IDLE) ? s_paddr_i : r_addr;

  assign m_paddr_o   = r_addr;
  assign m_pwdata_o  = r_wdata;
  assign m_pwrite_o  = r_write;
  assign m_psel_o    = w_act ? (NUM_SLV'(1) << r_idx) : '0;
  assign m_penable_o = (r_state == ACCESS);
  assign s_pready_o  = (r_state == RESP);
  assign s_prdata_o  = (r_state == RESP) ? r_rdata : '0;
  assign s_pslverr_o = (r_state == RESP) && r_slverr;
  assign err_valid_o = r_err_valid;
  assign err_type_o  = r_err_type;
  assign err_addr_o  = r_err_addr;
  assign err_cnt_o   = r_err_cnt;

  // Priority decode: scanning downward lets the lowest matching enabled rule win
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (rule_en_i[i] && s_paddr_i >= start_addr_i[i*ADDR_W +: ADDR_W] && s_paddr_i <= end_addr_i[i*ADDR_W +: ADDR_W]) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(i);
      end
    end
  end

  // Next-state logic for the one-outstanding transaction FSM
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? (w_hit ? SETUP : RESP) : IDLE;
      SETUP:   w_next = ACCESS;
      ACCESS:  w_next = (w_rdy || w_tout) ? RESP : ACCESS;
      default: w_next = IDLE;
    endcase
  end

  // State register; async reset drops downstream PSEL/PENABLE immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Request latch, response capture and ACCESS-cycle timeout counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_write  <= 1'b0;
      r_idx    <= '0;
      r_rdata  <= '0;
      r_slverr <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= s_paddr_i;
        r_wdata  <= s_pwdata_i;
        r_write  <= s_pwrite_i;
        r_idx    <= w_idx;
        r_rdata  <= w_hit ? '0 : ERR_D;
        r_slverr <= !w_hit;
      end
      if (r_state == ACCESS && w_rdy) begin
        r_rdata  <= m_prdata_i[int'(r_idx)*DATA_W +: DATA_W];
        r_slverr <= m_pslverr_i[r_idx];
      end else if (r_state == ACCESS && w_tout) begin
        r_rdata  <= ERR_D;
        r_slverr <= 1'b1;
      end
      r_cnt <= (r_state == SETUP) ? '0 : (r_state == ACCESS) ? r_cnt + 1'b1 : r_cnt;
    end
  end

  // Sticky first-error log and saturating error counter; a new error beats a clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_valid <= 1'b0;
      r_err_type  <= 1'b0;
      r_err_addr  <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_err && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
      if (w_err && (!r_err_valid || err_clr_i)) begin
        r_err_valid <= 1'b1;
        r_err_type  <= (r_state == ACCESS);
        r_err_addr  <= w_err_addr;
      end else if (err_clr_i) begin
        r_err_valid <= 1'b0;
        r_err_type  <= 1'b0;
        r_err_addr  <= '0;
      end
    end
  end
endmodule
